// File: rtl/illegal_instruction_exception_unit.sv
// Illegal-instruction trap sequencer: absorbs a decode-flagged illegal instruction, stalls decode,
// waits for older work to drain, then raises a cause-2 exception. Latency: detect N -> exception_valid N+2 at best.
// Backpressure: exception held until exception_ack; decode_stall high whenever not IDLE. Optional: ILLEGAL_INSTR_COUNTER_EN.
module illegal_instruction_exception_unit #(
    parameter int ID_W    = 3,
    parameter int TVAL_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            decode_valid,
    input  logic            decode_illegal,
    input  logic [31:0]     decode_instruction,
    input  logic [31:0]     decode_pc,
    input  logic [ID_W-1:0] decode_id,
    output logic            decode_stall,
    input  logic            pipeline_empty,
    input  logic            flush,
    output logic            exception_valid,
    output logic [4:0]      exception_code,
    output logic [31:0]     exception_pc,
    output logic [31:0]     exception_tval,
    output logic [ID_W-1:0] exception_id,
    input  logic            exception_ack,
    output logic [31:0]     illegal_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     tval_q, tval_d;
    logic [ID_W-1:0] id_q, id_d;

    // Next-state and capture: detect in IDLE, wait for drain (flush cancels), hold report until ack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (decode_valid && decode_illegal && !flush) begin
                    pc_d    = decode_pc;
                    tval_d  = (TVAL_EN != 0) ? decode_instruction : 32'h0;
                    id_d    = decode_id;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // flush has priority: an older redirect makes this instruction wrong-path
                if (flush) begin
                    state_d = IDLE;
                end else if (pipeline_empty) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // flush ignored here: the exception is already the oldest instruction
                if (exception_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            tval_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            id_q    <= id_d;
        end
    end

    assign decode_stall    = (state_q != IDLE);
    assign exception_valid = (state_q == REPORT);
    assign exception_code  = 5'd2;
    assign exception_pc    = pc_q;
    assign exception_tval  = tval_q;
    assign exception_id    = id_q;

`ifdef ILLEGAL_INSTR_COUNTER_EN
    logic [31:0] count_q, count_d;

    // Count delivered exceptions only; saturate instead of wrapping.
    always_comb begin
        count_d = count_q;
        if ((state_q == REPORT) && exception_ack && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign illegal_count = count_q;
`else
    assign illegal_count = 32'h0;
`endif

endmodule

// File: tb/tb_illegal_instruction_exception_unit.sv
// Bench for illegal_instruction_exception_unit: directed table, hand sequences, random vs. reference model.
// Drives inputs after the rising edge, checks outputs 1 time unit after the next edge.
// Second instance with TVAL_EN=0 shares all inputs.
module tb_illegal_instruction_exception_unit;

    logic        clk = 1'b0;
    logic        rst, decode_valid, decode_illegal, pipeline_empty, flush, exception_ack;
    logic [31:0] decode_instruction, decode_pc;
    logic [2:0]  decode_id;
    logic        decode_stall, exception_valid;
    logic [4:0]  exception_code;
    logic [31:0] exception_pc, exception_tval, illegal_count;
    logic [2:0]  exception_id;
    logic        decode_stall0, exception_valid0;
    logic [4:0]  exception_code0;
    logic [31:0] exception_pc0, exception_tval0, illegal_count0;
    logic [2:0]  exception_id0;

    always #5 clk = ~clk;

    illegal_instruction_exception_unit #(.ID_W(3), .TVAL_EN(1)) dut (
        .clk(clk), .rst(rst), .decode_valid(decode_valid), .decode_illegal(decode_illegal),
        .decode_instruction(decode_instruction), .decode_pc(decode_pc), .decode_id(decode_id),
        .decode_stall(decode_stall), .pipeline_empty(pipeline_empty), .flush(flush),
        .exception_valid(exception_valid), .exception_code(exception_code),
        .exception_pc(exception_pc), .exception_tval(exception_tval), .exception_id(exception_id),
        .exception_ack(exception_ack), .illegal_count(illegal_count));

    illegal_instruction_exception_unit #(.ID_W(3), .TVAL_EN(0)) dut_notval (
        .clk(clk), .rst(rst), .decode_valid(decode_valid), .decode_illegal(decode_illegal),
        .decode_instruction(decode_instruction), .decode_pc(decode_pc), .decode_id(decode_id),
        .decode_stall(decode_stall0), .pipeline_empty(pipeline_empty), .flush(flush),
        .exception_valid(exception_valid0), .exception_code(exception_code0),
        .exception_pc(exception_pc0), .exception_tval(exception_tval0), .exception_id(exception_id0),
        .exception_ack(exception_ack), .illegal_count(illegal_count0));

    typedef struct {
        logic        rst, dv, di;
        logic [31:0] instr, pc;
        logic [2:0]  id;
        logic        pe, fl, ack;
    } in_t;

    typedef struct {
        in_t         i;
        logic        exp_vld, exp_stall;
        logic [31:0] exp_pc, exp_tval;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model: one pending trap at most, delivered once older work is gone.
    bit          m_pending, m_ready;
    logic [31:0] m_pc, m_tval;
    logic [2:0]  m_id;
    longint      m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic in_t idle_in();
        in_t v;
        v = '{rst: 1'b0, dv: 1'b0, di: 1'b0, instr: 32'h0, pc: 32'h0, id: 3'd0,
              pe: 1'b1, fl: 1'b0, ack: 1'b0};
        return v;
    endfunction

    function automatic in_t det_in(input logic [31:0] pc, input logic [31:0] instr, input logic [2:0] id);
        in_t v;
        v = idle_in();
        v.dv = 1'b1; v.di = 1'b1; v.pc = pc; v.instr = instr; v.id = id;
        return v;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef ILLEGAL_INSTR_COUNTER_EN
        return m_count[31:0];
`else
        return 32'h0;
`endif
    endfunction

    task automatic step(input in_t v);
        rst = v.rst; decode_valid = v.dv; decode_illegal = v.di; decode_instruction = v.instr;
        decode_pc = v.pc; decode_id = v.id; pipeline_empty = v.pe; flush = v.fl; exception_ack = v.ack;
        @(posedge clk);
        if (v.rst) begin
            m_pending = 0; m_ready = 0; m_count = 0; m_pc = 0; m_tval = 0; m_id = 0;
        end else if (!m_pending) begin
            if (v.dv && v.di && !v.fl) begin
                m_pending = 1; m_ready = 0; m_pc = v.pc; m_tval = v.instr; m_id = v.id;
            end
        end else if (!m_ready) begin
            if (v.fl) m_pending = 0;
            else if (v.pe) m_ready = 1;
        end else if (v.ack) begin
            m_pending = 0; m_ready = 0;
            if (m_count < 64'hFFFF_FFFF) m_count++;
        end
        #1;
        chk("valid", {31'd0, exception_valid}, {31'd0, m_ready});
        chk("stall", {31'd0, decode_stall}, {31'd0, m_pending});
        chk("code", {27'd0, exception_code}, 32'd2);
        chk("pc", exception_pc, m_pc);
        chk("tval", exception_tval, m_tval);
        chk("id", {29'd0, exception_id}, {29'd0, m_id});
        chk("count", illegal_count, exp_count());
        chk("valid_notval", {31'd0, exception_valid0}, {31'd0, m_ready});
        chk("pc_notval", exception_pc0, m_pc);
        chk("tval_notval", exception_tval0, 32'h0);
    endtask

    task automatic deliver(input logic [31:0] pc, input logic [31:0] instr);
        in_t v;
        step(det_in(pc, instr, 3'd1));
        step(idle_in());
        v = idle_in(); v.ack = 1'b1;
        step(v);
        chk("deliver_idle", {31'd0, exception_valid}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        in_t v;
        logic [31:0] pc_hold;

        // Directed table: single illegal with empty pipeline, legal pass-through, detect+flush.
        tbl[0] = '{i: det_in(32'h80, 32'hFFFF_FFFF, 3'd5), exp_vld: 0, exp_stall: 1, exp_pc: 32'h80, exp_tval: 32'hFFFF_FFFF};
        tbl[1] = '{i: idle_in(), exp_vld: 1, exp_stall: 1, exp_pc: 32'h80, exp_tval: 32'hFFFF_FFFF};
        tbl[2] = '{i: idle_in(), exp_vld: 1, exp_stall: 1, exp_pc: 32'h80, exp_tval: 32'hFFFF_FFFF};
        tbl[3] = '{i: idle_in(), exp_vld: 0, exp_stall: 0, exp_pc: 32'h80, exp_tval: 32'hFFFF_FFFF};
        tbl[3].i.ack = 1'b1;
        tbl[4] = '{i: det_in(32'h100, 32'h1234_5678, 3'd2), exp_vld: 0, exp_stall: 0, exp_pc: 32'h80, exp_tval: 32'hFFFF_FFFF};
        tbl[4].i.di = 1'b0;
        tbl[5] = '{i: det_in(32'h200, 32'h0BAD_0BAD, 3'd3), exp_vld: 0, exp_stall: 0, exp_pc: 32'h80, exp_tval: 32'hFFFF_FFFF};
        tbl[5].i.fl = 1'b1;
        tbl[6] = '{i: det_in(32'h300, 32'h0000_0000, 3'd4), exp_vld: 0, exp_stall: 1, exp_pc: 32'h300, exp_tval: 32'h0};

        v = idle_in(); v.rst = 1'b1;
        step(v);
        step(v);
        chk("rst_valid", {31'd0, exception_valid}, 32'd0);
        chk("rst_stall", {31'd0, decode_stall}, 32'd0);
        chk("rst_pc", exception_pc, 32'h0);
        chk("rst_tval", exception_tval, 32'h0);
        chk("rst_id", {29'd0, exception_id}, 32'd0);
        chk("rst_count", illegal_count, 32'h0);

        for (int k = 0; k < 7; k++) begin
            step(tbl[k].i);
            chk($sformatf("tbl%0d_valid", k), {31'd0, exception_valid}, {31'd0, tbl[k].exp_vld});
            chk($sformatf("tbl%0d_stall", k), {31'd0, decode_stall}, {31'd0, tbl[k].exp_stall});
            chk($sformatf("tbl%0d_pc", k), exception_pc, tbl[k].exp_pc);
            chk($sformatf("tbl%0d_tval", k), exception_tval, tbl[k].exp_tval);
        end
        chk("tval0_pc", exception_pc0, 32'h300);
        // finish the TVAL_EN=0 case: report, check, ack
        step(idle_in());
        chk("tval0_valid", {31'd0, exception_valid0}, 32'd1);
        chk("tval0_tval", exception_tval0, 32'h0);
        v = idle_in(); v.ack = 1'b1;
        step(v);

        // Drain wait: pipeline busy 5 cycles after capture.
        step(det_in(32'h400, 32'hDEAD_BEEF, 3'd6));
        for (int k = 0; k < 5; k++) begin
            v = idle_in(); v.pe = 1'b0;
            step(v);
            chk("drain_stall", {31'd0, decode_stall}, 32'd1);
            chk("drain_novalid", {31'd0, exception_valid}, 32'd0);
        end
        step(idle_in());
        chk("drain_valid", {31'd0, exception_valid}, 32'd1);
        v = idle_in(); v.ack = 1'b1;
        step(v);

        // Flush in DRAIN together with pipeline_empty: flush wins.
        step(det_in(32'h500, 32'hCAFE_0001, 3'd7));
        v = idle_in(); v.fl = 1'b1;
        step(v);
        chk("flush_novalid", {31'd0, exception_valid}, 32'd0);
        chk("flush_nostall", {31'd0, decode_stall}, 32'd0);
        step(idle_in());
        chk("flush_still_idle", {31'd0, exception_valid}, 32'd0);

        // Ack backpressure with a flush pulse in REPORT.
        step(det_in(32'h600, 32'hFACE_B00C, 3'd1));
        step(idle_in());
        pc_hold = exception_pc;
        for (int k = 0; k < 4; k++) begin
            v = idle_in(); v.fl = (k == 1);
            step(v);
            chk("bp_valid", {31'd0, exception_valid}, 32'd1);
            chk("bp_pc", exception_pc, 32'h600);
            chk("bp_stable", exception_pc, pc_hold);
            chk("bp_tval", exception_tval, 32'hFACE_B00C);
        end
        v = idle_in(); v.ack = 1'b1;
        step(v);
        chk("bp_done", {31'd0, exception_valid}, 32'd0);
        step(idle_in());
        chk("bp_single", {31'd0, exception_valid}, 32'd0);

        // Counter: 3 reported + 1 flushed, then reset mid-REPORT.
        v = idle_in(); v.rst = 1'b1;
        step(v);
        deliver(32'h700, 32'h1);
        deliver(32'h704, 32'h2);
        step(det_in(32'h708, 32'h3, 3'd2));
        v = idle_in(); v.fl = 1'b1;
        step(v);
        deliver(32'h70C, 32'h4);
`ifdef ILLEGAL_INSTR_COUNTER_EN
        chk("cnt_three", illegal_count, 32'd3);
`else
        chk("cnt_tied", illegal_count, 32'd0);
`endif
        step(det_in(32'h710, 32'h5, 3'd3));
        step(idle_in());
        chk("cnt_in_report", {31'd0, exception_valid}, 32'd1);
        v = idle_in(); v.rst = 1'b1;
        step(v);
        chk("rst_mid_valid", {31'd0, exception_valid}, 32'd0);
        chk("rst_mid_count", illegal_count, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rst   = ($urandom_range(0, 199) == 0);
            v.dv    = $urandom_range(0, 1);
            v.di    = $urandom_range(0, 1);
            v.instr = $urandom;
            v.pc    = $urandom;
            v.id    = 3'($urandom_range(0, 7));
            v.pe    = $urandom_range(0, 1);
            v.fl    = ($urandom_range(0, 6) == 0);
            v.ack   = ($urandom_range(0, 4) < 2);
            step(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
